ram_overriding: RTL and testbench
=================================

Name: ram_overriding

Overview:
- Simple dual-port synchronous RAM, 16 words x 64 bits.
- Has one write port and one read port, both on a single clock.
- Write-through "overriding": a read from the address being written in the same cycle returns the new write data, not the stale stored word.
- Used as a small register-file / scratch buffer wherever same-cycle read-after-write coherency is required.

Parameters:
- DATA_WIDTH, 64, width of each word and of the write_data/read_data buses.
- ADDR_WIDTH, 4, width of read_addr/write_addr.
- DEPTH, 16 (2**ADDR_WIDTH), number of words; every address is valid.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- re  input  1  read enable.
- we  input  1  write enable.
- write_data  input  DATA_WIDTH  data to store at write_addr.
- read_data  output  DATA_WIDTH  registered read result.
- read_addr  input  ADDR_WIDTH  read address.
- write_addr  input  ADDR_WIDTH  write address.

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Port names are clk and reset.
- Reset (rising edge of clk with reset==0):
  - All DEPTH words are cleared to 0.
  - read_data is cleared to 0.
  - we and re are ignored; reset has priority over everything.
- Reset held low for several cycles: memory and read_data stay 0.
- Normal operation is every rising edge with reset==1.
- Write:
  - If we==1, mem[write_addr] <= write_data.
  - If we==0, memory is unchanged.
- Read:
  - If re==1, read_data <= (we==1 && write_addr==read_addr) ? write_data : mem[read_addr].
  - If re==0, read_data holds its previous value.
- Read latency: 1 clock. Data sampled at edge N is visible on read_data after edge N.
- Read of a word written at an earlier edge returns the stored value.
- Simultaneous read and write:
  - Same address: the bypass (override) returns write_data, and the memory is also updated.
  - Different addresses: both operations proceed independently.
- Memory contains no X after the first reset. A read of a never-written address after reset returns 0.
- Writes with we==1 and an unchanged address on consecutive edges overwrite; the last value wins.
- No error or overflow conditions exist. Addresses cannot go out of range because DEPTH == 2**ADDR_WIDTH.
- read_data is a pure register output: no combinational path from inputs to read_data.
- Inputs changing between edges (e.g. driven on the falling edge) have no effect until the next rising edge.

Test Plan:
- Reset: hold reset=0 for 2 edges with we=1, write_addr=3, write_data=0xAA. Then release, re=1, read_addr=3 -> read_data=0 one cycle later (the write was ignored under reset).
- Basic write/read: reset=1; we=1, write_addr=5, write_data=5 for one edge; then we=0. Next cycle re=1, read_addr=5 -> read_data=64'd5 after the following edge. Then re=0 -> read_data stays 5.
- Override: we=1, re=1, write_addr=read_addr=9, write_data=0x1234 on one edge -> read_data=0x1234 after that edge. A later read of address 9 also returns 0x1234.
- Independent ports: mem[2]=0x22 preloaded; same edge we=1, write_addr=7, write_data=0x77 and re=1, read_addr=2 -> read_data=0x22. Next read of address 7 -> 0x77.
- Full sweep: write data=addr*0x0101010101010101 to all 16 addresses, then read 0..15 -> each matches. Address 15 and address 0 are checked explicitly.
- Reset mid-operation: after the sweep, assert reset=0 for one edge while we=1, re=1 -> read_data=0. Subsequent reads of all 16 addresses return 0.

Source files
------------

// File: rtl/ram_overriding.sv
//------------------------------------------------------------------------------
// Module   : ram_overriding
// Function : 16x64 simple dual-port RAM whose read port bypasses a same-cycle
//            write to the same address.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ram_overriding #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  re,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [ADDR_WIDTH-1:0] write_addr
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_read_data;
    logic                  w_bypass;
    logic [DATA_WIDTH-1:0] w_read_next;

    // A write landing on the address being read wins over the stale word.
    assign w_bypass    = we && (write_addr == read_addr);
    assign w_read_next = w_bypass ? write_data : r_mem[read_addr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_read_data <= '0;
        end else begin
            if (we) begin
                r_mem[write_addr] <= write_data;
            end
            if (re) begin
                r_read_data <= w_read_next;
            end
        end
    end

    assign read_data = r_read_data;

endmodule

`default_nettype wire

// File: tb/tb_ram_overriding.sv
//------------------------------------------------------------------------------
// Module   : tb_ram_overriding
// Function : Scoreboard bench for ram_overriding with directed and random traffic.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_overriding;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [63:0] write_data = '0;
    logic [63:0] read_data;
    logic [3:0]  read_addr = '0;
    logic [3:0]  write_addr = '0;

    ram_overriding dut (
        .clk        (clk),
        .reset      (reset),
        .re         (re),
        .we         (we),
        .write_data (write_data),
        .read_data  (read_data),
        .read_addr  (read_addr),
        .write_addr (write_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model_mem [16];
    logic [63:0] model_rd;
    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference: what the read register must hold after the coming edge.
    task automatic step(input logic rn, input logic w, input logic [3:0] wa,
                        input logic [63:0] wd, input logic r, input logic [3:0] ra,
                        input string nm);
        @(negedge clk);
        reset = rn; we = w; write_addr = wa; write_data = wd;
        re = r; read_addr = ra;
        if (!rn) begin
            for (int i = 0; i < 16; i++) model_mem[i] = 64'd0;
            model_rd = 64'd0;
        end else begin
            if (r) model_rd = (w && wa == ra) ? wd : model_mem[ra];
            if (w) model_mem[wa] = wd;
        end
        sb.push_back('{model_rd, nm});
    endtask

    // Monitor: one expected value per edge, compared shortly after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_tests++;
                if (read_data !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: read_data=%h expected=%h", e.name, read_data, e.exp);
                end
            end
        end
    end

    initial begin
        // Writes under reset must be discarded.
        step(0, 1, 4'd3, 64'hAA, 0, 4'd0, "reset_a");
        step(0, 1, 4'd3, 64'hAA, 0, 4'd0, "reset_b");
        step(1, 0, 4'd0, 64'd0, 1, 4'd3, "read_after_reset");

        step(1, 1, 4'd5, 64'd5, 0, 4'd0, "write5_hold");
        step(1, 0, 4'd0, 64'd0, 1, 4'd5, "read5");
        step(1, 0, 4'd0, 64'd0, 0, 4'd0, "read5_hold");

        step(1, 1, 4'd9, 64'h1234, 1, 4'd9, "override9");
        step(1, 0, 4'd0, 64'd0, 1, 4'd9, "reread9");

        step(1, 1, 4'd2, 64'h22, 0, 4'd0, "preload2");
        step(1, 1, 4'd7, 64'h77, 1, 4'd2, "indep_read2");
        step(1, 0, 4'd0, 64'd0, 1, 4'd7, "read7");

        for (int a = 0; a < 16; a++)
            step(1, 1, 4'(a), 64'(a) * 64'h0101010101010101, 0, 4'd0, "sweep_wr");
        for (int a = 0; a < 16; a++)
            step(1, 0, 4'd0, 64'd0, 1, 4'(a), "sweep_rd");

        step(0, 1, 4'd4, 64'hDEAD, 1, 4'd4, "mid_reset");
        for (int a = 0; a < 16; a++)
            step(1, 0, 4'd0, 64'd0, 1, 4'(a), "post_reset_rd");

        for (int k = 0; k < 400; k++)
            step(($urandom_range(0, 49) != 0) ? 1'b1 : 1'b0,
                 1'($urandom), 4'($urandom), {$urandom, $urandom},
                 1'($urandom), 4'($urandom_range(0, 15)), "random");

        @(posedge clk);
        #3;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: left=%0d expected=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
